// File: rtl/jpeg_bit_streamer.sv
//------------------------------------------------------------------------------
// Module      : jpeg_bit_streamer
// Description : Serializes a byte-wide JPEG entropy-coded segment MSB first,
//               one bit per cycle, as a bit/is_new stream. With
//               JPEG_BIT_STREAMER_STUFFING_EN defined it also removes 0xFF00
//               stuffing, drops 0xFF fill bytes and halts on the first marker.
//               The serial output port is named serial_bit because "bit" is
//               a reserved word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module jpeg_bit_streamer #(
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_data,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   pause,
  input  logic                   resume,
  output logic                   serial_bit,
  output logic                   is_new,
  output logic                   marker_found,
  output logic [7:0]             marker_code,
  output logic [COUNT_WIDTH-1:0] bit_count,
  output logic                   busy
);

`ifdef JPEG_BIT_STREAMER_STUFFING_EN
  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FF     = 2'd2,
    S_MARKER = 2'd3
  } state_t;
`else
  typedef enum logic [0:0] {
    S_LOAD  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;
`endif

  state_t                 state, state_n;
  logic [7:0]             shifter, shifter_n;
  logic [3:0]             count, count_n;
  logic                   serial_bit_n, is_new_n;
  logic [COUNT_WIDTH-1:0] bit_count_n;
  logic                   accept;
  logic                   classify;

  // Byte handshake: open when the shifter is empty, a 0xFF is pending, or the
  // last bit is leaving this cycle so the next byte follows without a gap.
  always_comb begin
    byte_ready = 1'b0;
    if (!rst) begin
      case (state)
        S_LOAD:  byte_ready = 1'b1;
        S_SHIFT: byte_ready = (count == 4'd1) && !pause;
`ifdef JPEG_BIT_STREAMER_STUFFING_EN
        S_FF:    byte_ready = 1'b1;
`endif
        default: byte_ready = 1'b0;
      endcase
    end
  end

  assign accept = byte_valid && byte_ready;

`ifdef JPEG_BIT_STREAMER_STUFFING_EN
  logic       marker_found_r, marker_found_n;
  logic [7:0] marker_code_r, marker_code_n;
  assign marker_found = marker_found_r;
  assign marker_code  = marker_code_r;
  assign busy         = (state == S_SHIFT) || (state == S_FF);
`else
  logic unused_resume;
  assign unused_resume = resume;
  assign marker_found  = 1'b0;
  assign marker_code   = 8'h00;
  assign busy          = (state == S_SHIFT);
`endif

  // Next-state and datapath: emit one bit per unpaused SHIFT cycle, classify accepted bytes.
  always_comb begin
    state_n      = state;
    shifter_n    = shifter;
    count_n      = count;
    serial_bit_n = serial_bit;
    is_new_n     = 1'b0;
    bit_count_n  = bit_count;
    classify     = 1'b0;
`ifdef JPEG_BIT_STREAMER_STUFFING_EN
    marker_found_n = marker_found_r;
    marker_code_n  = marker_code_r;
`endif
    case (state)
      S_LOAD: begin
        classify = accept;
      end
      S_SHIFT: begin
        if (!pause) begin
          serial_bit_n = shifter[7];
          is_new_n     = 1'b1;
          shifter_n    = {shifter[6:0], 1'b0};
          count_n      = count - 4'd1;
          bit_count_n  = bit_count + COUNT_WIDTH'(1);
          if (count == 4'd1) begin
            state_n  = S_LOAD;
            classify = accept;
          end
        end
      end
`ifdef JPEG_BIT_STREAMER_STUFFING_EN
      S_FF: begin
        if (accept) begin
          if (byte_data == 8'h00) begin
            shifter_n = 8'hFF;
            count_n   = 4'd8;
            state_n   = S_SHIFT;
          end else if (byte_data != 8'hFF) begin
            marker_found_n = 1'b1;
            marker_code_n  = byte_data;
            state_n        = S_MARKER;
          end
        end
      end
      S_MARKER: begin
        if (resume) begin
          marker_found_n = 1'b0;
          state_n        = S_LOAD;
        end
      end
`endif
      default: state_n = S_LOAD;
    endcase

    // A newly accepted byte either parks as a pending 0xFF or fills the shifter.
    if (classify) begin
`ifdef JPEG_BIT_STREAMER_STUFFING_EN
      if (byte_data == 8'hFF) begin
        state_n = S_FF;
      end else
`endif
      begin
        shifter_n = byte_data;
        count_n   = 4'd8;
        state_n   = S_SHIFT;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      shifter    <= 8'h00;
      count      <= 4'd0;
      serial_bit <= 1'b0;
      is_new     <= 1'b0;
      bit_count  <= '0;
`ifdef JPEG_BIT_STREAMER_STUFFING_EN
      marker_found_r <= 1'b0;
      marker_code_r  <= 8'h00;
`endif
    end else begin
      state      <= state_n;
      shifter    <= shifter_n;
      count      <= count_n;
      serial_bit <= serial_bit_n;
      is_new     <= is_new_n;
      bit_count  <= bit_count_n;
`ifdef JPEG_BIT_STREAMER_STUFFING_EN
      marker_found_r <= marker_found_n;
      marker_code_r  <= marker_code_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jpeg_bit_streamer.sv
//------------------------------------------------------------------------------
// Module      : tb_jpeg_bit_streamer
// Description : Directed self-checking bench for jpeg_bit_streamer.
//               Sections depending on JPEG_BIT_STREAMER_STUFFING_EN follow
//               the same macro.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_jpeg_bit_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        pause = 1'b0;
  logic        resume = 1'b0;
  logic        serial_bit;
  logic        is_new;
  logic        marker_found;
  logic [7:0]  marker_code;
  logic [23:0] bit_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bq[$];
  logic [31:0] got;
  int          npulse, first_idx, last_idx, win_pulse;

  jpeg_bit_streamer #(.COUNT_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .pause(pause), .resume(resume),
    .serial_bit(serial_bit), .is_new(is_new), .marker_found(marker_found),
    .marker_code(marker_code), .bit_count(bit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feed queued bytes and collect emitted bits for ncyc edges.
  // psched bit i drives pause before edge i; pulses on edges in [wlo,whi] are counted separately.
  task automatic run(input int ncyc, input logic [63:0] psched, input int wlo, input int whi);
    logic acc;
    got = 0; npulse = 0; first_idx = -1; last_idx = -1; win_pulse = 0;
    for (int i = 0; i < ncyc; i++) begin
      byte_valid = (bq.size() > 0);
      byte_data  = (bq.size() > 0) ? bq[0] : 8'h00;
      pause      = psched[i];
      #1;
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) void'(bq.pop_front());
      if (is_new) begin
        got = {got[30:0], serial_bit};
        npulse++;
        if (first_idx < 0) first_idx = i;
        last_idx = i;
        if (i >= wlo && i <= whi) win_pulse++;
      end
    end
    byte_valid = 1'b0;
    pause      = 1'b0;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("rst_byte_ready", byte_ready, 0);
    @(posedge clk); #1;
    chk("rst_is_new", is_new, 0);
    chk("rst_bit", serial_bit, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_marker_found", marker_found, 0);
    chk("rst_marker_code", marker_code, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_byte_ready", byte_ready, 1);

    // Back-to-back 0xA5, 0x3C
    bq = '{8'hA5, 8'h3C};
    run(20, 64'd0, 0, -1);
    chk("b2b_pulses", npulse, 16);
    chk("b2b_bits", got[15:0], 16'hA53C);
    chk("b2b_first", first_idx, 1);
    chk("b2b_nogap", last_idx - first_idx + 1, 16);
    chk("b2b_bit_count", bit_count, 16);
    chk("b2b_idle_busy", busy, 0);

    // 0x81 with pause for 3 cycles after the second bit
    bq = '{8'h81};
    run(14, 64'h38, 3, 5);
    chk("pause_pulses", npulse, 8);
    chk("pause_bits", got[7:0], 8'h81);
    chk("pause_window", win_pulse, 0);
    chk("pause_span", last_idx - first_idx + 1, 11);
    chk("pause_bit_count", bit_count, 24);

    // Reset after 4 bits of 0xF0, then 0x0F
    bq = '{8'hF0};
    run(5, 64'd0, 0, -1);
    chk("mid_pulses", npulse, 4);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_byte_ready", byte_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_is_new", is_new, 0);
    chk("mid_rst_bit_count", bit_count, 0);
    chk("mid_rst_busy", busy, 0);
    bq = '{8'h0F};
    run(12, 64'd0, 0, -1);
    chk("after_rst_pulses", npulse, 8);
    chk("after_rst_bits", got[7:0], 8'h0F);
    chk("after_rst_bit_count", bit_count, 8);

`ifdef JPEG_BIT_STREAMER_STUFFING_EN
    // Stuffed 0xFF00 followed by 0x12
    bq = '{8'hFF, 8'h00, 8'h12};
    run(22, 64'd0, 0, -1);
    chk("stuff_pulses", npulse, 16);
    chk("stuff_bits", got[15:0], 16'hFF12);
    chk("stuff_first", first_idx, 2);
    chk("stuff_bit_count", bit_count, 24);

    // Fill byte then EOI marker
    bq = '{8'hFF, 8'hFF, 8'hD9};
    run(6, 64'd0, 0, -1);
    chk("marker_pulses", npulse, 0);
    chk("marker_found", marker_found, 1);
    chk("marker_code", marker_code, 8'hD9);
    chk("marker_byte_ready", byte_ready, 0);
    chk("marker_busy", busy, 0);
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    #1;
    chk("resume_marker_found", marker_found, 0);
    chk("resume_byte_ready", byte_ready, 1);
    chk("resume_code_kept", marker_code, 8'hD9);
`else
    // Verbatim 0xFF, 0xD8
    bq = '{8'hFF, 8'hD8};
    run(20, 64'd0, 0, -1);
    chk("verb_pulses", npulse, 16);
    chk("verb_bits", got[15:0], 16'hFFD8);
    chk("verb_marker_found", marker_found, 0);
    chk("verb_bit_count", bit_count, 24);
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("verb_resume_ignored", marker_found, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jpeg_bit_streamer.md
# jpeg_bit_streamer

Converts a byte-wide JPEG entropy-coded segment into the serial `bit`/`is_new` stream that the decoder consumes, MSB first, one bit per cycle. Removes JPEG byte stuffing (0xFF 0x00 becomes 0xFF), discards 0xFF fill bytes, and stops at the first marker (0xFF followed by a byte other than 0x00 or 0xFF), reporting its code. Sits between the compressed-image byte source (ROM/FIFO) and the decoder's bit input.

## Interface
- `COUNT_WIDTH`, 24: width of the emitted-bit counter.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `byte_data`  in  8  compressed byte from source.
- `byte_valid`  in  1  `byte_data` valid.
- `byte_ready`  out  1  byte accepted on edge where `byte_valid && byte_ready`.
- `pause`  in  1  decoder stall; freezes bit emission.
- `resume`  in  1  one-cycle pulse; leaves marker state.
- `bit`  out  1  current serial bit (registered).
- `is_new`  out  1  registered one-cycle strobe: `bit` carries a new bit this cycle.
- `marker_found`  out  1  high while halted on a marker.
- `marker_code`  out  8  second byte of the detected marker.
- `bit_count`  out  COUNT_WIDTH  bits emitted since reset; wraps modulo 2^COUNT_WIDTH.
- `busy`  out  1  high in SHIFT or FF state.

## Operation
- States: LOAD (shifter empty), SHIFT (emitting), FF (holding a 0xFF, awaiting next byte), MARKER (halted).
- Byte classification on acceptance, shared by LOAD and SHIFT reload:
  - 0xFF → FF; nothing loaded.
  - any other value → shifter = byte, count = 8, SHIFT.
- FF state, accepted byte n:
  - n = 0x00 → shifter = 0xFF, count = 8, SHIFT.
  - n = 0xFF → fill byte, discarded; stay FF.
  - otherwise → `marker_found`=1, `marker_code`=n, MARKER.
- SHIFT, `pause`=0: register `bit` = shifter[7], `is_new`=1, shift left, count−1, `bit_count`+1.
  - When count reaches 0 with no byte accepted: go to LOAD.
- SHIFT, `pause`=1: no shift, `is_new`=0, `bit` holds, count holds.
- MARKER: `byte_ready`=0, `is_new`=0. A `resume` pulse clears `marker_found`, keeps `marker_code`, and goes to LOAD. `resume` has no effect in any other state.
- `byte_ready` (combinational from state) = 1 in LOAD and FF, and in SHIFT only when count=1 and `pause`=0. It is 0 in MARKER and while `rst`=1.
- A byte accepted in SHIFT with count=1 takes effect on the same edge that emits the last bit, so back-to-back bytes stream with no gap.
- `pause` never blocks byte acceptance in LOAD or FF.

## Timing
- Reset values: `bit`=0, `is_new`=0, `marker_found`=0, `marker_code`=0x00, `bit_count`=0, `busy`=0, state LOAD. `byte_ready`=0 during the reset cycle.
- `rst` has priority over every other input. Asserting it mid-byte discards the shifter and any pending 0xFF; the cycle after reset shows `is_new`=0.
- Latency: byte accepted on edge k → first `is_new`=1 with MSB after edge k+1. Eight bits occupy edges k+1..k+8.
- Stuffed pair 0xFF,0x00 accepted on edges k, k+1 → first bit after edge k+2.
- Sustained throughput: 1 bit/cycle with `byte_valid` held high and `pause` low.
- `is_new` is never high for two cycles carrying the same bit.

## Configuration
- `JPEG_BIT_STREAMER_STUFFING_EN` defined: stuffing removal, fill-byte discard and marker detection as above; FF and MARKER states exist.
- Macro undefined: every byte is serialized verbatim, including 0xFF and the byte after it. FF and MARKER states are not compiled. `marker_found` and `marker_code` are tied to 0, and `resume` is ignored.

## Test plan
- 0xA5, 0x3C back-to-back with `byte_valid` high → 16 consecutive `is_new` pulses, bits 1010010100111100, no gap, `bit_count`=16.
- 0xFF, 0x00, 0x12 (macro defined) → 16 bits 1111111100010010, the 0x00 is never emitted, `bit_count`=16.
- 0xFF, 0xFF, 0xD9 (macro defined) → no `is_new` pulses; `marker_found`=1, `marker_code`=0xD9, `byte_ready`=0. A `resume` pulse then gives `marker_found`=0 and `byte_ready`=1.
- 0x81 with `pause` high for 3 cycles after the 2nd bit → `is_new` low for those 3 cycles; 8 pulses total across 11 cycles; bits 10000001.
- `rst` pulsed after 4 bits of 0xF0 → next cycle `is_new`=0 and `bit_count`=0. A following 0x0F emits exactly 00001111.
- Macro undefined, 0xFF, 0xD8 → 16 bits 1111111111011000; `marker_found` stays 0.
